dm_lsu_ctrl: RTL

Load/store controller between the core's memory stage and the word-organised data memory (combinational read port, write-on-posedge port, word index = address bits [7:2]). It decodes RISC-V funct3 access width, extracts and sign/zero-extends sub-word loads, and performs a two-cycle read-modify-write for SB/SH because the memory has only a whole-word write enable. It also flags misaligned or illegal accesses and stalls the core while a read-modify-write is in flight.

---
 rtl/dm_lsu_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dm_lsu_ctrl.sv
// dm_lsu_ctrl - load/store controller between the core memory stage and a
// word-organised data memory (combinational read, write on posedge).
//
// State table
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a request; loads, SW and errors finish in 1 cycle
//   S_MERGE | writing back the read-modified word of an SB/SH
//
// Ports
//   clk_i, rst_n_i       clock, async active-low reset
//   req_i, we_i          request strobe, 1 = store
//   funct3_i             RISC-V access width (B/H/W/BU/HU)
//   addr_i, wd_i         byte address, right-aligned store data
//   ready_o              request accepted this cycle when high
//   valid_o, err_o       completion pulse, err_o qualifies a rejected access
//   rdata_o              last successful load result
//   mem_addr_o, mem_wd_o, mem_we_o, mem_rd_i   data memory port
module dm_lsu_ctrl #(
    parameter int AW = 6
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wd_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_rd_i
);

    typedef enum logic {S_IDLE, S_MERGE} state_e;

    state_e         state_q, state_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [31:0]    mword_q, mword_d;
    logic [15:0]    mwd_q, mwd_d;
    logic [AW-1:0]  midx_q, midx_d;
    logic [1:0]     mlane_q, mlane_d;
    logic           mhalf_q, mhalf_d;

    logic           is_half, is_word, legal, misal, acc_err;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_val;
    logic [31:0]    mmask, merged;

    // Access decode and error detection
    always_comb begin
        is_half = (funct3_i[1:0] == 2'b01);
        is_word = (funct3_i == 3'b010);
        if (we_i) legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        else      legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010)
                       || (funct3_i == 3'b100) || (funct3_i == 3'b101);
        misal   = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
        acc_err = !legal || misal;
    end

    // Load lane extraction and extension
    always_comb begin
        ld_byte = 8'(mem_rd_i >> {addr_i[1:0], 3'b000});
        ld_half = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (funct3_i)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_rd_i;
        endcase
    end

    // Lane replacement for the write-back of a sub-word store
    always_comb begin
        if (mhalf_q) mmask = 32'h0000_FFFF << {mlane_q[1], 4'b0000};
        else         mmask = 32'h0000_00FF << {mlane_q, 3'b000};
        merged = (mword_q & ~mmask) | (({16'h0, mwd_q} << {mlane_q, 3'b000}) & mmask);
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        mword_d    = mword_q;
        mwd_d      = mwd_q;
        midx_d     = midx_q;
        mlane_d    = mlane_q;
        mhalf_d    = mhalf_q;
        ready_o    = 1'b0;
        mem_addr_o = addr_i;
        mem_wd_o   = wd_i;
        mem_we_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (req_i) begin
                    valid_d = 1'b1;
                    if (acc_err) begin
                        err_d = 1'b1;
                    end else if (!we_i) begin
                        rdata_d = ld_val;
                    end else if (is_word) begin
                        mem_we_o = 1'b1;
                    end else begin
                        // Sub-word store: snapshot the word now, write it back next cycle
                        valid_d = 1'b0;
                        mword_d = mem_rd_i;
                        mwd_d   = wd_i[15:0];
                        midx_d  = addr_i[AW+1:2];
                        mlane_d = addr_i[1:0];
                        mhalf_d = is_half;
                        state_d = S_MERGE;
                    end
                end
            end
            S_MERGE: begin
                mem_addr_o = {{(30-AW){1'b0}}, midx_q, 2'b00};
                mem_wd_o   = merged;
                mem_we_o   = 1'b1;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            mword_q <= '0;
            mwd_q   <= '0;
            midx_q  <= '0;
            mlane_q <= '0;
            mhalf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            mword_q <= mword_d;
            mwd_q   <= mwd_d;
            midx_q  <= midx_d;
            mlane_q <= mlane_d;
            mhalf_q <= mhalf_d;
        end
    end

    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule
